// File: rtl/ofm_writeback_if.sv
// Word-write bus from the OFM writeback engine to the OFM buffer memory.
// The master holds wr_addr/wr_data stable while wr_en is high until wr_ready.
interface ofm_writeback_if #(
  parameter int ADDR_W = 32
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/ofm_writeback.sv
// Buffers per-window PE cluster result vectors and writes each one
// as four packed 32-bit words into the OFM region of the buffer memory.
module ofm_writeback #(
  parameter int NUM_PE     = 16,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            OFM_W,
  input  logic [7:0]            OFM_C,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [NUM_PE-1:0]     valid_in,
  input  logic [8*NUM_PE-1:0]   ofm_in,
  ofm_writeback_if.master       wb,
  output logic                  busy,
  output logic                  done_compute,
  output logic                  cfg_err,
  output logic                  overflow
);

  localparam int VEC_W = 8 * NUM_PE;
  localparam int PW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_t;

  state_t state, state_nxt;

  logic [7:0]        w_r;
  logic [5:0]        words_r;
  logic [ADDR_W-1:0] base_r;
  logic [15:0]       pixel;
  logic [3:0]        tile;
  logic [1:0]        k;
  logic [VEC_W-1:0]  hold;
  logic [VEC_W-1:0]  mem [FIFO_DEPTH];
  logic [PW:0]       wptr, rptr;

  logic        cfg_ok, start_ok, fifo_empty, fifo_full;
  logic        accept, vec_end, last_pix, last_tile, last_vec;
  logic        pop, push_req, push, drop;
  logic [15:0] total_pix;
  logic        unused_valid;

  assign unused_valid = ^valid_in[NUM_PE-1:1];

  assign cfg_ok     = (OFM_W != 8'd0) && (OFM_C != 8'd0) && (OFM_C[3:0] == 4'd0);
  assign start_ok   = (state == IDLE) && start && cfg_ok;
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);

  // words_r holds OFM_C/4, so its upper bits are the tile count
  assign total_pix = 16'(w_r) * 16'(w_r);
  assign last_pix  = (pixel == total_pix - 16'd1);
  assign last_tile = (tile == words_r[5:2] - 4'd1);
  assign last_vec  = last_pix && last_tile;
  assign accept    = (state == WRITE) && wb.wr_ready;
  assign vec_end   = accept && (k == 2'd3);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nxt = RUN;
      RUN: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (vec_end) begin
          if (last_vec)         state_nxt = DONE;
          else if (!fifo_empty) pop = 1'b1;
          else                  state_nxt = RUN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A full FIFO still takes a push when the head leaves in the same cycle
  assign push_req = (state != IDLE) && valid_in[0];
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[PW-1:0]] <= ofm_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_r      <= '0;
      words_r  <= '0;
      base_r   <= '0;
      pixel    <= '0;
      tile     <= '0;
      k        <= '0;
      hold     <= '0;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && start && !cfg_ok;
      if (start_ok) begin
        w_r      <= OFM_W;
        words_r  <= OFM_C[7:2];
        base_r   <= base_addr;
        pixel    <= '0;
        tile     <= '0;
        k        <= '0;
        wptr     <= '0;
        rptr     <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop) begin
          hold <= mem[rptr[PW-1:0]];
          rptr <= rptr + 1'b1;
          k    <= '0;
        end else if (accept) begin
          k <= k + 2'd1;
        end
        // Pixel-major order inside a channel tile, tiles outermost
        if (vec_end) begin
          if (last_pix) begin
            pixel <= '0;
            tile  <= tile + 4'd1;
          end else begin
            pixel <= pixel + 16'd1;
          end
        end
        if (drop) overflow <= 1'b1;
      end
    end
  end

  assign wb.wr_en   = (state == WRITE);
  assign wb.wr_addr = base_r + ADDR_W'(pixel) * ADDR_W'(words_r) + ADDR_W'({tile, k});
  assign wb.wr_data = hold[{k, 5'd0} +: 32];

  assign busy         = (state == RUN) || (state == WRITE);
  assign done_compute = (state == DONE);

endmodule
